// File: rtl/psu_pwrok_monitor.sv
// PSU power-on sequencer: drives PS_ON and qualifies PWROK with debounce and timeout.
// Optional macro PSU_PWROK_GLITCH_FILTER_EN tolerates short PWROK drops while ON.
module psu_pwrok_monitor #(
    parameter int DEBOUNCE_CYC      = 2000,
    parameter int GLITCH_CYC        = 20,
    parameter int TIMEOUT_SHORT_CYC = 100000,
    parameter int TIMEOUT_LONG_CYC  = 2000000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iPsOnReq,
    input  logic       iPsuPwrOk,
    input  logic       iTimeoutSel,
    output logic       oPsuEn,
    output logic       oPsuGood,
    output logic       oPsuFault,
    output logic [1:0] oFaultCode
);

    localparam int               DEB_W        = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [20:0]      TIMER_MAX    = '1;
    localparam logic [20:0]      SHORT_TARGET = 21'(TIMEOUT_SHORT_CYC);
    localparam logic [20:0]      LONG_TARGET  = 21'(TIMEOUT_LONG_CYC);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_LOST    = 2'b10;

    if (DEBOUNCE_CYC < 1 || GLITCH_CYC < 1 ||
        TIMEOUT_SHORT_CYC > 2097151 || TIMEOUT_LONG_CYC > 2097151) begin : g_bad_params
        $error("psu_pwrok_monitor: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAIT_OK,
        ST_ON,
        ST_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [20:0]      timer_q, timer_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic             sel_q, sel_d;
    logic [1:0]       code_q, code_d;
    logic             en_q, en_d;
    logic             good_q, good_d;
    logic             fault_q, fault_d;
    logic             sync1_q, sync2_q;
    logic             pwrok_s;
    logic             pwrok_lost;
    logic [20:0]      target;

    assign pwrok_s = sync2_q;

`ifdef PSU_PWROK_GLITCH_FILTER_EN
    localparam int              GL_W    = $clog2(GLITCH_CYC + 1);
    localparam logic [GL_W-1:0] GL_LAST = GL_W'(GLITCH_CYC - 1);
    logic [GL_W-1:0] glitch_q, glitch_d;
    // Loss is declared on the GLITCH_CYC-th consecutive low sample.
    assign pwrok_lost = !pwrok_s && (glitch_q == GL_LAST);
`else
    assign pwrok_lost = !pwrok_s;
`endif

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        deb_d    = deb_q;
        sel_d    = sel_q;
        code_d   = code_q;
`ifdef PSU_PWROK_GLITCH_FILTER_EN
        glitch_d = glitch_q;
`endif
        target   = sel_q ? SHORT_TARGET : LONG_TARGET;

        // Dropping the request overrides every other transition.
        if (!iPsOnReq) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_WAIT_OK;
                    timer_d = '0;
                    deb_d   = '0;
                    sel_d   = iTimeoutSel;
                    code_d  = FC_NONE;
                end
                ST_WAIT_OK: begin
                    if (timer_q != TIMER_MAX) timer_d = timer_q + 21'd1;
                    deb_d = pwrok_s ? deb_q + DEB_W'(1) : '0;
                    // Debounce completion has priority over a simultaneous timeout.
                    if (pwrok_s && (deb_q == DEB_LAST)) begin
                        state_d  = ST_ON;
`ifdef PSU_PWROK_GLITCH_FILTER_EN
                        glitch_d = '0;
`endif
                    end else if (timer_q == target) begin
                        state_d = ST_FAULT;
                        code_d  = FC_TIMEOUT;
                    end
                end
                ST_ON: begin
`ifdef PSU_PWROK_GLITCH_FILTER_EN
                    glitch_d = pwrok_s ? '0 : glitch_q + GL_W'(1);
`endif
                    if (pwrok_lost) begin
                        state_d = ST_FAULT;
                        code_d  = FC_LOST;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_OFF;
            endcase
        end

        en_d    = (state_d == ST_WAIT_OK) || (state_d == ST_ON);
        good_d  = (state_d == ST_ON);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= ST_OFF;
            timer_q  <= '0;
            deb_q    <= '0;
            sel_q    <= 1'b0;
            code_q   <= FC_NONE;
            en_q     <= 1'b0;
            good_q   <= 1'b0;
            fault_q  <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
`ifdef PSU_PWROK_GLITCH_FILTER_EN
            glitch_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            deb_q    <= deb_d;
            sel_q    <= sel_d;
            code_q   <= code_d;
            en_q     <= en_d;
            good_q   <= good_d;
            fault_q  <= fault_d;
            sync1_q  <= iPsuPwrOk;
            sync2_q  <= sync1_q;
`ifdef PSU_PWROK_GLITCH_FILTER_EN
            glitch_q <= glitch_d;
`endif
        end
    end

    assign oPsuEn     = en_q;
    assign oPsuGood   = good_q;
    assign oPsuFault  = fault_q;
    assign oFaultCode = code_q;

endmodule

// File: tb/tb_psu_pwrok_monitor.sv
// Self-checking bench for psu_pwrok_monitor, built with shortened debounce/timeout parameters.
// Expectations follow PSU_PWROK_GLITCH_FILTER_EN when that macro is defined.
module tb_psu_pwrok_monitor;

    localparam int DEB     = 200;
    localparam int GLITCH  = 20;
    localparam int T_SHORT = 1000;
    localparam int T_LONG  = 4000;

    // Output vector order: {en, good, fault, code[1:0]}
    localparam logic [4:0] O_OFF   = 5'b00000;
    localparam logic [4:0] O_WAIT  = 5'b10000;
    localparam logic [4:0] O_ON    = 5'b11000;
    localparam logic [4:0] O_TMO   = 5'b00101;
    localparam logic [4:0] O_LOST  = 5'b00110;
    localparam logic [4:0] O_OFF01 = 5'b00001;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iPsOnReq;
    logic       iPsuPwrOk;
    logic       iTimeoutSel;
    logic       oPsuEn;
    logic       oPsuGood;
    logic       oPsuFault;
    logic [1:0] oFaultCode;
    logic [4:0] outs;

    int checks   = 0;
    int failures = 0;

    psu_pwrok_monitor #(
        .DEBOUNCE_CYC      (DEB),
        .GLITCH_CYC        (GLITCH),
        .TIMEOUT_SHORT_CYC (T_SHORT),
        .TIMEOUT_LONG_CYC  (T_LONG)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iPsOnReq    (iPsOnReq),
        .iPsuPwrOk   (iPsuPwrOk),
        .iTimeoutSel (iTimeoutSel),
        .oPsuEn      (oPsuEn),
        .oPsuGood    (oPsuGood),
        .oPsuFault   (oPsuFault),
        .oFaultCode  (oFaultCode)
    );

    assign outs = {oPsuEn, oPsuGood, oPsuFault, oFaultCode};

    always #5 iClk = ~iClk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic enter_wait(input logic sel);
        iTimeoutSel = sel;
        iPsOnReq    = 1'b1;
        step(1);
    endtask

    task automatic power_off();
        iPsOnReq  = 1'b0;
        iPsuPwrOk = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        iRst_n = 1'b0; iPsOnReq = 1'b1; iPsuPwrOk = 1'b1; iTimeoutSel = 1'b1;
        step(3);
        checks++;
        if (outs !== O_OFF) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b want %b", outs, O_OFF);
        end
        iRst_n = 1'b1;
        step(1);
        checks++;
        if (outs !== O_WAIT) begin
            failures++;
            $display("[TB] FAIL reset_release_wait: got %b want %b", outs, O_WAIT);
        end
        power_off();
        checks++;
        if (outs !== O_OFF) begin
            failures++;
            $display("[TB] FAIL reset_then_off: got %b want %b", outs, O_OFF);
        end
    endtask

    task automatic test_power_good();
        int  r;
        logic ok;
        r  = $urandom_range(400, 20);
        ok = 1'b1;
        enter_wait(1'b1);
        for (int i = 0; i < r; i++) begin
            step(1);
            if (outs !== O_WAIT) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL good_wait_hold: got %b want %b", outs, O_WAIT);
        end
        iPsuPwrOk = 1'b1;
        step(DEB + 1);
        checks++;
        if (outs !== O_WAIT) begin
            failures++;
            $display("[TB] FAIL good_not_early: got %b want %b", outs, O_WAIT);
        end
        step(1);
        checks++;
        if (outs !== O_ON) begin
            failures++;
            $display("[TB] FAIL good_on_time: got %b want %b", outs, O_ON);
        end
        step(50);
        checks++;
        if (outs !== O_ON) begin
            failures++;
            $display("[TB] FAIL good_stable: got %b want %b", outs, O_ON);
        end
        power_off();
    endtask

    task automatic test_timeout_short();
        int n;
        int seen;
        n = 0; seen = -1;
        enter_wait(1'b1);
        iTimeoutSel = 1'b0;
        while (n < T_SHORT + 20 && seen < 0) begin
            step(1);
            n++;
            if (oPsuFault === 1'b1) seen = n;
        end
        checks++;
        if (seen != T_SHORT + 1) begin
            failures++;
            $display("[TB] FAIL timeout_short_cycle: got %0d want %0d", seen, T_SHORT + 1);
        end
        checks++;
        if (outs !== O_TMO) begin
            failures++;
            $display("[TB] FAIL timeout_short_outputs: got %b want %b", outs, O_TMO);
        end
        step(30);
        checks++;
        if (outs !== O_TMO) begin
            failures++;
            $display("[TB] FAIL fault_hold: got %b want %b", outs, O_TMO);
        end
        iPsOnReq = 1'b0;
        step(1);
        checks++;
        if (outs !== O_OFF01) begin
            failures++;
            $display("[TB] FAIL off_code_retained: got %b want %b", outs, O_OFF01);
        end
        enter_wait(1'b1);
        checks++;
        if (outs !== O_WAIT) begin
            failures++;
            $display("[TB] FAIL code_clear_on_wait: got %b want %b", outs, O_WAIT);
        end
        power_off();
    endtask

    task automatic test_timeout_long();
        int   n;
        int   seen;
        int   off;
        logic saw_good;
        n = 0; seen = -1; saw_good = 1'b0;
        off = $urandom_range(299, 0);
        enter_wait(1'b0);
        while (n < T_LONG + 20 && seen < 0) begin
            iPsuPwrOk = (((n + off) % 300) < 150);
            step(1);
            n++;
            if (oPsuGood === 1'b1) saw_good = 1'b1;
            if (oPsuFault === 1'b1) seen = n;
        end
        checks++;
        if (seen != T_LONG + 1) begin
            failures++;
            $display("[TB] FAIL timeout_long_cycle: got %0d want %0d", seen, T_LONG + 1);
        end
        checks++;
        if (saw_good !== 1'b0 || outs !== O_TMO) begin
            failures++;
            $display("[TB] FAIL timeout_long_outputs: good_seen=%b got %b want good_seen=0 %b",
                     saw_good, outs, O_TMO);
        end
        power_off();
    endtask

    task automatic test_glitch(input int len);
        int         fault_at;
        int         bad_n;
        logic [4:0] exp_v;
        logic [4:0] bad_act;
        logic [4:0] bad_exp;
        bad_n = -1; bad_act = '0; bad_exp = '0;
`ifdef PSU_PWROK_GLITCH_FILTER_EN
        fault_at = (len >= GLITCH) ? 2 + GLITCH : 0;
`else
        fault_at = 3;
`endif
        iPsuPwrOk = 1'b1;
        enter_wait(1'b1);
        step(DEB + 2);
        checks++;
        if (outs !== O_ON) begin
            failures++;
            $display("[TB] FAIL glitch_pre_on len=%0d: got %b want %b", len, outs, O_ON);
        end
        iPsuPwrOk = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            step(1);
            if (n == len) iPsuPwrOk = 1'b1;
            exp_v = (fault_at != 0 && n >= fault_at) ? O_LOST : O_ON;
            if (outs !== exp_v && bad_n < 0) begin
                bad_n = n; bad_act = outs; bad_exp = exp_v;
            end
        end
        checks++;
        if (bad_n >= 0) begin
            failures++;
            $display("[TB] FAIL glitch len=%0d cycle=%0d: got %b want %b", len, bad_n, bad_act, bad_exp);
        end
        power_off();
    endtask

    task automatic test_reset_mid();
        enter_wait(1'b1);
        step(50);
        iRst_n = 1'b0;
        step(1);
        checks++;
        if (outs !== O_OFF) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait: got %b want %b", outs, O_OFF);
        end
        iRst_n = 1'b1;
        iPsOnReq = 1'b0;
        step(3);
        checks++;
        if (outs !== O_OFF) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_after: got %b want %b", outs, O_OFF);
        end
        iPsuPwrOk = 1'b1;
        enter_wait(1'b1);
        step(DEB + 2);
        iRst_n = 1'b0;
        step(1);
        checks++;
        if (outs !== O_OFF) begin
            failures++;
            $display("[TB] FAIL reset_mid_on: got %b want %b", outs, O_OFF);
        end
        iRst_n = 1'b1;
        power_off();
    endtask

    // PWROK rises so that the final debounce sample lands delta cycles after the timeout cycle.
    task automatic test_coincide(input int delta);
        int         k;
        int         t_on;
        int         t_end;
        logic [4:0] exp_final;
        k     = T_SHORT - DEB - 1 + delta;
        t_on  = k + DEB + 2;
        t_end = (t_on <= T_SHORT + 1) ? t_on : T_SHORT + 1;
        exp_final = (t_on <= T_SHORT + 1) ? O_ON : O_TMO;
        enter_wait(1'b1);
        step(k);
        iPsuPwrOk = 1'b1;
        step(t_end - 1 - k);
        checks++;
        if (outs !== O_WAIT) begin
            failures++;
            $display("[TB] FAIL coincide_pre delta=%0d: got %b want %b", delta, outs, O_WAIT);
        end
        step(1);
        checks++;
        if (outs !== exp_final) begin
            failures++;
            $display("[TB] FAIL coincide delta=%0d: got %b want %b", delta, outs, exp_final);
        end
        power_off();
    endtask

    task automatic test_random_wait();
        bit         w [0:T_SHORT];
        int         c;
        int         run;
        int         jd;
        int         exp_t;
        bit         lvl;
        bit         s;
        logic       ok;
        logic [4:0] exp_final;
        for (int it = 0; it < 6; it++) begin
            c = 0;
            lvl = 1'($urandom_range(1, 0));
            while (c <= T_SHORT) begin
                run = lvl ? $urandom_range(DEB + 60, DEB / 2) : $urandom_range(40, 1);
                for (int i = 0; i < run && c <= T_SHORT; i++) begin
                    w[c] = lvl;
                    c++;
                end
                lvl = !lvl;
            end
            // The block sees w[j-2] in WAIT_OK cycle j; find the first DEB-long run of highs.
            run = 0; jd = -1;
            for (int j = 0; j <= T_SHORT; j++) begin
                s   = (j >= 2) ? w[j - 2] : 1'b0;
                run = s ? run + 1 : 0;
                if (run >= DEB && jd < 0) jd = j;
            end
            exp_t     = (jd >= 0) ? jd + 1 : T_SHORT + 1;
            exp_final = (jd >= 0) ? O_ON : O_TMO;
            ok = 1'b1;
            enter_wait(1'b1);
            for (int n = 0; n < exp_t; n++) begin
                iPsuPwrOk = w[n];
                step(1);
                if (n + 1 < exp_t && outs !== O_WAIT) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL random_wait_hold iter=%0d: left WAIT_OK before cycle %0d", it, exp_t);
            end
            checks++;
            if (outs !== exp_final) begin
                failures++;
                $display("[TB] FAIL random_result iter=%0d cycle=%0d: got %b want %b",
                         it, exp_t, outs, exp_final);
            end
            power_off();
        end
    endtask

    initial begin
        iRst_n = 1'b0; iPsOnReq = 1'b0; iPsuPwrOk = 1'b0; iTimeoutSel = 1'b0;
        test_reset();
        test_power_good();
        test_timeout_short();
        test_timeout_long();
        test_glitch(10);
        test_glitch(25);
        test_glitch(GLITCH - 1);
        test_glitch(GLITCH);
        test_glitch($urandom_range(40, 1));
        test_reset_mid();
        test_coincide(-1);
        test_coincide(0);
        test_coincide(1);
        test_random_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
